multicycle_control_unit: RTL

Sequencing controller for the multicycle RV32I core. It walks each instruction through fetch, decode, execute, memory and write-back, and drives the 3-bit ALU-op code into the existing ALU control decoder. It also drives every datapath enable and mux select, and the memory request handshake. It sits between the instruction register (opcode in) and the datapath/memory interface (strobes out).

---
 rtl/mc_ctrl_pkg.sv | 34 +++
 rtl/multicycle_control_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I sequencer: FSM states, opcodes,
// and the ALU-op codes understood by the ALU control decoder.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_EXEC_U   = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_MEM_WR   = 4'd7,
    ST_ALU_WB   = 4'd8,
    ST_MEM_WB   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_OP_R      = 3'b000;
  localparam logic [2:0] ALU_OP_I      = 3'b001;
  localparam logic [2:0] ALU_OP_U      = 3'b010;
  localparam logic [2:0] ALU_OP_LOAD   = 3'b011;
  localparam logic [2:0] ALU_OP_STORE  = 3'b100;
  localparam logic [2:0] ALU_OP_BRANCH = 3'b101;

endpackage

// File: rtl/multicycle_control_unit.sv
// Multicycle sequencer: walks each instruction through fetch/decode/execute/
// memory/write-back, drives datapath strobes and counts retired instructions.
module multicycle_control_unit
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_write_o,
  output logic        addr_src_o,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic        pc_src_o,
  output logic        alu_src_a_o,
  output logic        alu_src_b_o,
  output logic [2:0]  alu_op_o,
  output logic        reg_write_o,
  output logic        result_src_o,
  output logic        halted_o,
  output logic [31:0] instr_count_o,
  output logic [3:0]  state_o
);

  state_t      state_q, state_d;
  logic [31:0] instr_count_q;
  logic        retire;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_FETCH;
      instr_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instr_count_q <= instr_count_q + 32'd1;
    end
  end

  // Memory handshake: mem_req_o is valid, mem_ready_i is ready. A request
  // completes on the edge where both are 1; until then the state holds, so
  // mem_req_o/mem_write_o/addr_src_o stay stable. Ready is ignored without req.
  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    addr_src_o   = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 1'b0;
    alu_op_o     = ALU_OP_R;
    reg_write_o  = 1'b0;
    result_src_o = 1'b0;
    halted_o     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (opcode_i)
          OP_R:               state_d = ST_EXEC_R;
          OP_I:               state_d = ST_EXEC_I;
          OP_AUIPC:           state_d = ST_EXEC_U;
          OP_LOAD, OP_STORE:  state_d = ST_MEM_ADDR;
          OP_BRANCH:          state_d = ST_BRANCH;
          default:            state_d = ST_HALT;
        endcase
      end
      ST_EXEC_R: begin
        alu_op_o = ALU_OP_R;
        state_d  = ST_ALU_WB;
      end
      ST_EXEC_I: begin
        alu_op_o    = ALU_OP_I;
        alu_src_b_o = 1'b1;
        state_d     = ST_ALU_WB;
      end
      ST_EXEC_U: begin
        alu_op_o    = ALU_OP_U;
        alu_src_a_o = 1'b1;
        alu_src_b_o = 1'b1;
        state_d     = ST_ALU_WB;
      end
      ST_MEM_ADDR: begin
        alu_src_b_o = 1'b1;
        // The IR still holds the instruction, so the opcode picks load vs store.
        if (opcode_i == OP_STORE) begin
          alu_op_o = ALU_OP_STORE;
          state_d  = ST_MEM_WR;
        end else begin
          alu_op_o = ALU_OP_LOAD;
          state_d  = ST_MEM_RD;
        end
      end
      ST_MEM_RD: begin
        mem_req_o  = 1'b1;
        addr_src_o = 1'b1;
        if (mem_ready_i) state_d = ST_MEM_WB;
      end
      ST_MEM_WR: begin
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        addr_src_o  = 1'b1;
        if (mem_ready_i) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_ALU_WB: begin
        reg_write_o = 1'b1;
        retire      = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_MEM_WB: begin
        reg_write_o  = 1'b1;
        result_src_o = 1'b1;
        retire       = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_op_o   = ALU_OP_BRANCH;
        pc_src_o   = 1'b1;
        pc_write_o = ~zero_i;
        retire     = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_HALT: begin
        halted_o = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  assign instr_count_o = instr_count_q;
  assign state_o       = state_q;

endmodule
